// File: rtl/mem_responder_if.sv
// Request/hit bundle between the pipeline request unit and mem_responder.
// master = request unit (drives REN/WEN, addresses, store data);
// slave  = responder (drives ihit/dhit pulses and load data).
interface mem_responder_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic          ihit;
    logic          dhit;
    logic [DW-1:0] iload;
    logic [DW-1:0] dload;

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ihit, dhit, iload, dload
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ihit, dhit, iload, dload
    );
endinterface

// File: rtl/mem_responder.sv
// Variable-latency responder: arbitrates I/D requests onto a single-port RAM.
// Ports: CLK, RST (async, active-high); req = request bundle (slave side);
// ramREN/ramWEN/ramaddr/ramstore -> RAM, ramload/ramready <- RAM;
// err = sticky flag for simultaneous dREN and dWEN at a grant.
module mem_responder #(
    parameter int LAT    = 2,
    parameter int STARVE = 4,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic          CLK,
    input  logic          RST,
    mem_responder_if.slave req,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [DW-1:0] ramstore,
    input  logic [DW-1:0] ramload,
    input  logic          ramready,
    output logic          err
);
    localparam logic [3:0] LAT_C    = 4'(LAT);
    localparam logic [3:0] STARVE_C = 4'(STARVE);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t        state, state_n;
    logic          own_d;
    logic          wr;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] store_r;
    logic [DW-1:0] iload_r;
    logic [DW-1:0] dload_r;
    logic [3:0]    cnt;
    logic [3:0]    starve;
    logic          grant_i;
    logic          grant_d;
    logic          done;
    logic          data_req;

    assign data_req = req.dREN | req.dWEN;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    // Data normally wins; a full starve count hands one grant to iREN.
    always_comb begin
        state_n = state;
        grant_i = 1'b0;
        grant_d = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req.iREN && (!data_req || starve == STARVE_C)) begin
                    grant_i = 1'b1;
                    state_n = ACC;
                end else if (data_req) begin
                    grant_d = 1'b1;
                    state_n = ACC;
                end
            end
            ACC: begin
                if (cnt == LAT_C && ramready) begin
                    done    = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            own_d   <= 1'b0;
            wr      <= 1'b0;
            addr_r  <= '0;
            store_r <= '0;
            iload_r <= '0;
            dload_r <= '0;
            cnt     <= '0;
            starve  <= '0;
            err     <= 1'b0;
        end else if (grant_i || grant_d) begin
            own_d   <= grant_d;
            // A combined dREN/dWEN request is serviced as a write.
            wr      <= grant_d & req.dWEN;
            addr_r  <= grant_d ? req.daddr : req.iaddr;
            store_r <= req.dstore;
            cnt     <= '0;
            if (grant_d && req.dREN && req.dWEN)
                err <= 1'b1;
            if (grant_d && req.iREN) begin
                if (starve != STARVE_C)
                    starve <= starve + 4'd1;
            end else begin
                starve <= '0;
            end
        end else if (state == ACC) begin
            if (cnt != LAT_C)
                cnt <= cnt + 4'd1;
            if (done && !wr) begin
                if (own_d) dload_r <= ramload;
                else       iload_r <= ramload;
            end
        end
    end

    assign ramREN    = (state == ACC) && !wr;
    assign ramWEN    = (state == ACC) && wr;
    assign ramaddr   = addr_r;
    assign ramstore  = store_r;
    assign req.ihit  = (state == RESP) && !own_d;
    assign req.dhit  = (state == RESP) && own_d;
    assign req.iload = iload_r;
    assign req.dload = dload_r;
endmodule

// File: doc/mem_responder.md
# mem_responder

Responder end of the request/hit handshake used by the pipeline's request unit. Accepts held-level instruction-read (iREN) and data-read/write (dREN/dWEN) requests, arbitrates them onto a single-port RAM, waits a programmable minimum latency plus RAM readiness, and returns one-cycle ihit/dhit pulses with load data. Sits between the datapath's request unit and the RAM model, in place of a combinational memory controller, so variable-latency memory is exercised end to end.

## Interface
- LAT, 2, minimum wait cycles per access after issue (0..15)
- STARVE, 4, maximum consecutive data grants while iREN is pending (1..15)
- AW, 32, address width
- DW, 32, data width
- CLK  in  1  clock, rising edge
- RST  in  1  reset; asynchronous, active-high
- iREN  in  1  instruction read request; held high until ihit
- iaddr  in  AW  instruction address
- dREN  in  1  data read request; held high until dhit
- dWEN  in  1  data write request; held high until dhit
- daddr  in  AW  data address
- dstore  in  DW  write data
- ihit  out  1  one-cycle instruction completion pulse
- dhit  out  1  one-cycle data completion pulse
- iload  out  DW  instruction read data; valid while ihit=1, held afterwards
- dload  out  DW  data read data; valid while dhit=1, held afterwards
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  AW  RAM address
- ramstore  out  DW  RAM write data
- ramload  in  DW  RAM read data
- ramready  in  1  RAM completion; sampled only in ACC
- err  out  1  sticky: dREN and dWEN sampled high together

## Operation
- FSM states IDLE, ACC, RESP; reset state IDLE.
- IDLE: grant evaluated each edge. Data (dREN|dWEN) wins over iREN, except when starve count == STARVE and iREN=1, then instruction wins. No request: stay IDLE.
- On grant: latch owner (I/D), op (read/write), address, dstore into registers; cnt<=0; go ACC.
- dREN&dWEN both high at grant: serviced as write; err<=1 (cleared only by RST).
- Starve count: +1 (saturating at STARVE) on each data grant while iREN=1; cleared on every instruction grant and whenever iREN=0 at a grant edge.
- ACC: ramaddr/ramstore from latched registers; ramREN=1 for reads, ramWEN=1 for writes, both combinational from state+op, never both. cnt increments, saturating at LAT. Exit when cnt==LAT and ramready=1: read captures ramload into iload or dload by owner; go RESP.
- RESP: exactly one of ihit/dhit=1 (owner); RAM strobes 0; go IDLE unconditionally. Requester drops its REN on this edge, so IDLE never sees a stale request.
- Request deasserted during ACC: access completes and hit still pulses; no abort.
- Input address/data changes during ACC have no effect (latched).

## Timing
- Reset values: ihit=dhit=0, ramREN=ramWEN=0, ramaddr=0, ramstore=0, iload=dload=0, err=0, cnt=0, starve=0, state IDLE. Asserting RST mid-ACC drops strobes immediately (async); no hit issued.
- Request high before edge E0 in IDLE -> ACC from E0. With ramready=1, ACC lasts LAT+1 cycles; hit high in cycle after edge E0+LAT+1. Total request-to-hit = LAT+2 cycles including the request cycle; ramready low extends ACC cycle-for-cycle.
- Back-to-back: next grant earliest at the edge ending the IDLE cycle after RESP; throughput one access per LAT+3 cycles.
- ihit and dhit never high in the same cycle; hit width exactly 1 cycle.

## Test plan
- Reset: RST=1 with iREN=dREN=1 -> all outputs 0; release, ramready=1, LAT=2: ramREN high cycles 1-3, ihit... dhit pulses cycle 4, ihit never during that access.
- Single I-read, LAT=0, ramready=1, ramload=0x8C220004 -> ramREN 1 cycle, ihit 1 cycle later, iload=0x8C220004.
- D-write LAT=2, daddr=0x100, dstore=0xDEADBEEF; ramready low 3 extra cycles -> ramWEN for 6 cycles, ramaddr=0x100, ramstore=0xDEADBEEF, single dhit, dload unchanged.
- Starvation: iREN held, dREN re-raised each access, STARVE=4 -> grant order D,D,D,D,I,D...; ihit after 4th dhit.
- dREN=dWEN=1 -> write performed, err=1 and stays 1 until RST.
- RST asserted mid-ACC -> ramREN drops same cycle, no hit, next access after release completes normally.
